// File: rtl/alu_control_seq_pkg.sv
// alu_control_seq_pkg: ALU codes, opcodes, funct codes, mul/div op and FSM state types.
// Rev 1.0
`default_nettype none

package alu_control_seq_pkg;

  localparam int ALU_W = 4;

  localparam logic [ALU_W-1:0] ALU_AND = 4'h0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'h1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'h2;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'h3;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'h4;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'h5;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'h6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'h7;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'h8;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'hC;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MD_RUN  = 2'd1,
    S_MD_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_control_seq_funct_map.sv
// alu_funct_map: combinational opcode/funct/ALUop decode; illegal reporting gated by ALU_CTRL_ILLEGAL_TRAP_EN.
// Rev 1.0
`default_nettype none

module alu_funct_map
  import alu_control_seq_pkg::*;
(
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic [1:0]       alu_op_i,
  input  logic             pc_write_i,
  output logic [ALU_W-1:0] code_o,
  output logic             is_md_o,
  output md_op_e           md_op_o,
  output logic             illegal_o
);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic unknown;

  always_comb begin
    code_o  = ALU_ADD;
    is_md_o = 1'b0;
    md_op_o = MD_MULT;
    unknown = 1'b0;
    if (alu_op_i == 2'b00) begin
      if (!pc_write_i) begin
        case (opcode_i)
          OP_LW, OP_SW, OP_ADDI: code_o = ALU_ADD;
          OP_ANDI:               code_o = ALU_AND;
          OP_ORI:                code_o = ALU_OR;
          OP_XORI:               code_o = ALU_XOR;
          OP_SLTI:               code_o = ALU_SLT;
          default:               unknown = 1'b1;
        endcase
      end
    end else if (alu_op_i[0]) begin
      code_o = ALU_SUB;
    end else begin
      case (funct_i)
        F_SLL:   code_o = ALU_SLL;
        F_SRA:   code_o = ALU_SRA;
        F_SRL:   code_o = ALU_SRL;
        F_XOR:   code_o = ALU_XOR;
        F_ADD:   code_o = ALU_ADD;
        F_SUB:   code_o = ALU_SUB;
        F_AND:   code_o = ALU_AND;
        F_OR:    code_o = ALU_OR;
        F_SLT:   code_o = ALU_SLT;
        F_NOR:   code_o = ALU_NOR;
        F_JR:    code_o = ALU_ADD;
        F_MULT:  begin is_md_o = 1'b1; md_op_o = MD_MULT;  end
        F_MULTU: begin is_md_o = 1'b1; md_op_o = MD_MULTU; end
        F_DIV:   begin is_md_o = 1'b1; md_op_o = MD_DIV;   end
        F_DIVU:  begin is_md_o = 1'b1; md_op_o = MD_DIVU;  end
        default: unknown = 1'b1;
      endcase
    end
  end

  assign illegal_o = TRAP_EN & unknown;

endmodule

`default_nettype wire

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU decoder with mul/div sequencing and flush (option: ALU_CTRL_ILLEGAL_TRAP_EN).
// Rev 1.0
`default_nettype none

module alu_control_seq
  import alu_control_seq_pkg::*;
#(
  parameter int CTRL_W        = 4,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [1:0]        alu_op,
  input  logic              pc_write,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_abort,
  output logic              hilo_we,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               illegal_q, illegal_d;
  logic               md_start_q, md_start_d;
  md_op_e             md_op_q, md_op_d;

  logic [ALU_W-1:0]   dec_code;
  logic               dec_is_md;
  md_op_e             dec_md_op;
  logic               dec_illegal;
  logic               accept;

  alu_funct_map u_funct_map (
    .opcode_i   (opcode),
    .funct_i    (funct),
    .alu_op_i   (alu_op),
    .pc_write_i (pc_write),
    .code_o     (dec_code),
    .is_md_o    (dec_is_md),
    .md_op_o    (dec_md_op),
    .illegal_o  (dec_illegal)
  );

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    md_op_d     = md_op_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    md_start_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ctrl_d = CTRL_W'(dec_code);
          if (dec_is_md) begin
            state_d    = S_MD_RUN;
            cnt_d      = CNT_LOAD;
            md_start_d = 1'b1;
            md_op_d    = dec_md_op;
          end else begin
            out_valid_d = 1'b1;
            illegal_d   = dec_illegal;
          end
        end
      end
      S_MD_RUN: begin
        // Flush wins over completion: an aborted op never reaches MD_DONE.
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_MD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_MD_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= MD_MULT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !flush;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = out_valid_q || (state_q == S_MD_DONE);
  assign hilo_we     = (state_q == S_MD_DONE);
  assign md_abort    = (state_q == S_MD_RUN) && flush;
  assign md_start    = md_start_q;
  assign md_op       = md_op_q;
  assign alu_control = ctrl_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed + randomized checks of alu_control_seq against a cycle-age reference model.
// Rev 1.0
`default_nettype none

module tb_alu_control_seq;

  localparam int N = 4;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_XOR = 4'h3,
                         C_SLL = 4'h4, C_SRL = 4'h5, C_SUB = 4'h6, C_SLT = 4'h7,
                         C_SRA = 4'h8, C_NOR = 4'hC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, pc_write = 1'b0, flush = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [1:0] alu_op = '0;
  logic       in_ready, out_valid, illegal, md_start, md_abort, hilo_we, busy;
  logic [3:0] alu_control;
  logic [1:0] md_op;

  alu_control_seq #(.CTRL_W(4), .MULDIV_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .alu_op(alu_op), .pc_write(pc_write),
    .flush(flush), .out_valid(out_valid), .alu_control(alu_control),
    .illegal(illegal), .md_start(md_start), .md_op(md_op),
    .md_abort(md_abort), .hilo_we(hilo_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: age counts cycles since a mul/div accept (0 = idle); result state for single-cycle ops.
  int         age = 0;
  bit         m_ov = 0, m_ill = 0;
  logic [3:0] m_ctrl = '0;
  logic [1:0] m_mop = '0;

  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [1:0] ao, input bit pw,
                                     output logic [3:0] code, output bit md,
                                     output logic [1:0] mop, output bit ill);
    code = C_ADD; md = 0; mop = 2'd0; ill = 0;
    if (ao == 2'd0) begin
      if (!pw) begin
        case (op)
          6'h23, 6'h2B, 6'h08: code = C_ADD;
          6'h0C: code = C_AND;
          6'h0D: code = C_OR;
          6'h0E: code = C_XOR;
          6'h0A: code = C_SLT;
          default: ill = 1;
        endcase
      end
    end else if (ao == 2'd1 || ao == 2'd3) begin
      code = C_SUB;
    end else begin
      if (fn >= 6'h18 && fn <= 6'h1B) begin
        md = 1;
        mop = 2'(fn - 6'h18);
      end else begin
        case (fn)
          6'h00: code = C_SLL;
          6'h02: code = C_SRL;
          6'h03: code = C_SRA;
          6'h08: code = C_ADD;
          6'h20: code = C_ADD;
          6'h22: code = C_SUB;
          6'h24: code = C_AND;
          6'h25: code = C_OR;
          6'h26: code = C_XOR;
          6'h27: code = C_NOR;
          6'h2A: code = C_SLT;
          default: ill = 1;
        endcase
      end
    end
    ill = ill & TRAP;
  endfunction

  task automatic cyc(input bit v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [1:0] ao, input bit pw, input bit fl);
    bit run, done, acc, md, ill;
    logic [3:0] code;
    logic [1:0] mop;
    @(negedge clk);
    in_valid = v; opcode = op; funct = fn; alu_op = ao; pc_write = pw; flush = fl;
    #1;
    run  = (age >= 1) && (age <= N);
    done = (age == N + 1);
    chk("in_ready", in_ready, (age == 0) && !fl);
    chk("busy", busy, age != 0);
    chk("out_valid", out_valid, m_ov || done);
    chk("md_start", md_start, age == 1);
    chk("md_abort", md_abort, run && fl);
    chk("hilo_we", hilo_we, done);
    chk("illegal", illegal, m_ov ? m_ill : 1'b0);
    if (age != 0) chk("md_op", md_op, m_mop);
    if (m_ov) chk("alu_control", alu_control, m_ctrl);
    if (done) chk("alu_control_md", alu_control, C_ADD);
    acc = v && (age == 0) && !fl;
    if (age != 0) begin
      if ((run && fl) || done) age = 0;
      else age++;
    end
    m_ov = 0; m_ill = 0;
    if (acc) begin
      ref_decode(op, fn, ao, pw, code, md, mop, ill);
      if (md) begin
        age = 1; m_mop = mop; m_ctrl = C_ADD;
      end else begin
        m_ov = 1; m_ctrl = code; m_ill = ill;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 6'h00, 6'h00, 2'd0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_alu_control"}, alu_control, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_md_start"}, md_start, 0);
    chk({tag, "_md_op"}, md_op, 0);
    chk({tag, "_md_abort"}, md_abort, 0);
    chk({tag, "_hilo_we"}, hilo_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [5:0] op_list [8] = '{6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h3F};
  logic [5:0] fn_list [16] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B,
                               6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    idle(2);
    // NOR then SLTI back-to-back, then priority cases.
    cyc(1, 6'h00, 6'h27, 2'd2, 0, 0);
    cyc(1, 6'h0A, 6'h00, 2'd0, 0, 0);
    cyc(1, 6'h0C, 6'h00, 2'd0, 1, 0);
    cyc(1, 6'h00, 6'h24, 2'd3, 0, 0);
    cyc(1, 6'h00, 6'h3F, 2'd2, 0, 0);
    cyc(1, 6'h3F, 6'h00, 2'd0, 0, 0);
    idle(1);
    // DIVU full run, with in_valid held high while busy.
    cyc(1, 6'h00, 6'h1B, 2'd2, 0, 0);
    for (int i = 0; i < N + 1; i++) cyc(1, 6'h00, 6'h20, 2'd2, 0, 0);
    idle(2);
    // MULT flushed in the 2nd MD_RUN cycle with concurrent in_valid.
    cyc(1, 6'h00, 6'h18, 2'd2, 0, 0);
    cyc(0, 6'h00, 6'h00, 2'd0, 0, 0);
    cyc(1, 6'h00, 6'h20, 2'd2, 0, 1);
    idle(N + 2);
    // Flush in IDLE suppresses accept but not a pending result.
    cyc(1, 6'h00, 6'h22, 2'd2, 0, 0);
    cyc(1, 6'h00, 6'h25, 2'd2, 0, 1);
    idle(2);
    // Flush in MD_DONE: completion still reported.
    cyc(1, 6'h00, 6'h1A, 2'd2, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 6'h00, 6'h00, 2'd0, 0, 0);
    cyc(0, 6'h00, 6'h00, 2'd0, 0, 1);
    idle(1);
    // Async reset mid MD_RUN.
    cyc(1, 6'h00, 6'h19, 2'd2, 0, 0);
    idle(2);
    @(negedge clk);
    in_valid = 0; flush = 0;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    age = 0; m_ov = 0; m_ill = 0;
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 800; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 3) != 0) ? op_list[$urandom_range(0, 7)] : 6'($urandom);
      fn = ($urandom_range(0, 3) != 0) ? fn_list[$urandom_range(0, 15)] : 6'($urandom);
      cyc($urandom_range(0, 9) < 7, op, fn, 2'($urandom), 1'($urandom),
          $urandom_range(0, 15) == 0);
    end
    idle(N + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
